// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, default address map and read strobe value.
// Also used by the RISC-V/APB wrapper and the peripheral-side address map.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StDone   = 2'd3
  } apb_state_e;

  localparam int unsigned APB_BASE_DEFAULT    = 1000;
  localparam int unsigned SLAVE_SHIFT_DEFAULT = 8;

  localparam logic [3:0] PSTRB_READ = 4'b0000;

  // Width of a slave index; never zero so single-slave builds still elaborate.
  function automatic int unsigned idx_width(input int unsigned num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB peripheral bus as seen by one master and NUM_SLAVES slaves.
// Read data / ready / error are per-slave vectors; the master picks the selected slice.
interface apb_master_if #(
  parameter int unsigned NUM_SLAVES = 4
);

  logic [NUM_SLAVES-1:0]    PSEL;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [31:0]              PADDR;
  logic [31:0]              PWDATA;
  logic [3:0]               PSTRB;
  logic [32*NUM_SLAVES-1:0] PRDATA_ALL;
  logic [NUM_SLAVES-1:0]    PREADY_ALL;
  logic [NUM_SLAVES-1:0]    PSLVERR_ALL;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA_ALL, PREADY_ALL, PSLVERR_ALL
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA_ALL, PREADY_ALL, PSLVERR_ALL
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational byte address -> {slave index, in-window offset, decode error}.
// Shared with the peripheral-side address map so both agree on the window layout.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned APB_BASE    = APB_BASE_DEFAULT,
  parameter int unsigned SLAVE_SHIFT = SLAVE_SHIFT_DEFAULT,
  localparam int unsigned IdxW       = idx_width(NUM_SLAVES)
) (
  input  logic [31:0]     addr,
  output logic [IdxW-1:0] idx,
  output logic [31:0]     offset,
  output logic            decode_err
);

  logic [31:0] off;
  logic [31:0] idx_full;

  // Underflow is judged on the raw address; the wrapped difference is never trusted.
  always_comb begin
    off        = addr - 32'(APB_BASE);
    idx_full   = off >> SLAVE_SHIFT;
    offset     = off & ((32'd1 << SLAVE_SHIFT) - 32'd1);
    idx        = idx_full[IdxW-1:0];
    decode_err = (addr < 32'(APB_BASE)) || (idx_full >= 32'(NUM_SLAVES));
  end

endmodule

// File: rtl/apb_master.sv
// APB3/APB4 master behind the RISC-V/APB wrapper: decodes the target slave, runs
// SETUP/ACCESS, and returns a one-cycle READY with SLVERR and read data.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned APB_BASE       = APB_BASE_DEFAULT,
  parameter int unsigned SLAVE_SHIFT    = SLAVE_SHIFT_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         transfer,
  input  logic         SWRITE,
  input  logic [31:0]  SADDR,
  input  logic [31:0]  SWDATA,
  input  logic [3:0]   SSTRB,
  output logic         READY,
  output logic         SLVERR,
  output logic [31:0]  RDATA,
  apb_master_if.master apb
);

  localparam int unsigned IdxW = idx_width(NUM_SLAVES);
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  apb_state_e      state_q;
  logic            armed_q;
  logic [CntW-1:0] cnt_q;
  logic            write_q;
  logic [IdxW-1:0] idx_q;

  logic [IdxW-1:0] dec_idx;
  logic [31:0]     dec_off;
  logic            dec_err;

  apb_addr_decoder #(
    .NUM_SLAVES  (NUM_SLAVES),
    .APB_BASE    (APB_BASE),
    .SLAVE_SHIFT (SLAVE_SHIFT)
  ) u_decoder (
    .addr       (SADDR),
    .idx        (dec_idx),
    .offset     (dec_off),
    .decode_err (dec_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      armed_q     <= 1'b1;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      READY       <= 1'b0;
      SLVERR      <= 1'b0;
      RDATA       <= '0;
      apb.PSEL    <= '0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      apb.PSTRB   <= '0;
    end else begin
      READY <= 1'b0;
      // The wrapper holds transfer one cycle past READY; only a low cycle re-arms.
      if (!transfer) begin
        armed_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (transfer && armed_q) begin
            write_q     <= SWRITE;
            idx_q       <= dec_idx;
            apb.PWRITE  <= SWRITE;
            apb.PADDR   <= dec_off;
            apb.PWDATA  <= SWRITE ? SWDATA : 32'd0;
            apb.PSTRB   <= SWRITE ? SSTRB : PSTRB_READ;
            if (dec_err) begin
              state_q <= StDone;
              READY   <= 1'b1;
              SLVERR  <= 1'b1;
              if (!SWRITE) begin
                RDATA <= '0;
              end
            end else begin
              state_q  <= StSetup;
              apb.PSEL <= NUM_SLAVES'(1) << dec_idx;
            end
          end
        end

        StSetup: begin
          apb.PENABLE <= 1'b1;
          state_q     <= StAccess;
        end

        StAccess: begin
          if (apb.PREADY_ALL[idx_q]) begin
            SLVERR <= apb.PSLVERR_ALL[idx_q];
            if (!write_q) begin
              RDATA <= apb.PSLVERR_ALL[idx_q] ? 32'd0 : apb.PRDATA_ALL[32*int'(idx_q) +: 32];
            end
            READY       <= 1'b1;
            apb.PSEL    <= '0;
            apb.PENABLE <= 1'b0;
            state_q     <= StDone;
          end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            SLVERR <= 1'b1;
            if (!write_q) begin
              RDATA <= '0;
            end
            READY       <= 1'b1;
            apb.PSEL    <= '0;
            apb.PENABLE <= 1'b0;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StDone: begin
          SLVERR  <= 1'b0;
          armed_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: latency, wait states, decode errors, timeout,
// request re-arm after READY and asynchronous reset in the middle of a transfer.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        transfer = 1'b0;
  logic        SWRITE = 1'b0;
  logic [31:0] SADDR = '0;
  logic [31:0] SWDATA = '0;
  logic [3:0]  SSTRB = '0;
  logic        READY;
  logic        SLVERR;
  logic [31:0] RDATA;

  apb_master_if #(.NUM_SLAVES(4)) bus ();

  apb_master #(
    .NUM_SLAVES     (4),
    .APB_BASE       (1000),
    .SLAVE_SHIFT    (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .transfer (transfer),
    .SWRITE   (SWRITE),
    .SADDR    (SADDR),
    .SWDATA   (SWDATA),
    .SSTRB    (SSTRB),
    .READY    (READY),
    .SLVERR   (SLVERR),
    .RDATA    (RDATA),
    .apb      (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Slave behaviour for the current transfer.
  int         ws = 0;
  logic [3:0] tgt = 4'b0000;
  logic [3:0] bg_rdy = 4'b0000;

  // Observations from the last run_xfer.
  int          o_rc;
  int          o_acc;
  logic        o_err;
  logic [3:0]  o_psel;
  logic [3:0]  o_pstrb;
  logic [31:0] o_paddr;
  logic [31:0] o_pwdata;
  logic        o_psel_rdy;
  logic        o_pulse_ok;
  logic        o_rearm_ok;

  // Issue one request (transfer high from cycle 0) and play the selected slave.
  task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    @(negedge clk);
    SWRITE = w; SADDR = a; SWDATA = d; SSTRB = s; transfer = 1'b1;
    bus.PREADY_ALL = bg_rdy & ~tgt;
    o_rc = -1; o_acc = 0; o_err = 1'b0; o_psel = '0; o_pstrb = '0;
    o_paddr = '0; o_pwdata = '0; o_psel_rdy = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.PSEL != 4'b0000) begin
        o_psel  |= bus.PSEL;
        o_pstrb |= bus.PSTRB;
        if (!bus.PENABLE) begin
          o_paddr  = bus.PADDR;
          o_pwdata = bus.PWDATA;
        end
      end
      if (bus.PENABLE) begin
        o_acc++;
        bus.PREADY_ALL = (bg_rdy & ~tgt) | ((o_acc > ws) ? tgt : 4'b0000);
      end
      if (READY) begin
        o_rc = c; o_err = SLVERR; o_psel_rdy = |bus.PSEL;
        break;
      end
    end
    bus.PREADY_ALL = bg_rdy & ~tgt;
    @(negedge clk);
    o_pulse_ok = !READY;
    @(negedge clk);
    o_rearm_ok = !READY && (bus.PSEL == 4'b0000);
    transfer = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({READY, SLVERR, RDATA, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA,
         bus.PSTRB} !== 108'd0) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b err=%b rdata=%h psel=%b pen=%b", READY,
               SLVERR, RDATA, bus.PSEL, bus.PENABLE);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (READY !== 1'b0 || bus.PSEL !== 4'b0000) begin
      fails++;
      $display("FAIL reset_idle: got ready=%b psel=%b want 0/0000", READY, bus.PSEL);
    end
  endtask

  task automatic test_write();
    tgt = 4'b0010; ws = 0; bg_rdy = 4'b0000; bus.PSLVERR_ALL = 4'b0000;
    run_xfer(1'b1, 32'd1000 + 32'h104, 32'hDEADBEEF, 4'b0011);
    tests++;
    if (o_rc !== 3) begin fails++; $display("FAIL wr_latency: got %0d want 3", o_rc); end
    tests++;
    if (o_psel !== 4'b0010) begin fails++; $display("FAIL wr_psel: got %b want 0010", o_psel); end
    tests++;
    if (o_paddr !== 32'h04) begin fails++; $display("FAIL wr_paddr: got %h want 4", o_paddr); end
    tests++;
    if (o_pstrb !== 4'b0011 || o_pwdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL wr_data: got strb=%b data=%h want 0011/deadbeef", o_pstrb, o_pwdata);
    end
    tests++;
    if (o_err !== 1'b0) begin fails++; $display("FAIL wr_slverr: got %b want 0", o_err); end
    tests++;
    if (o_pulse_ok !== 1'b1) begin fails++; $display("FAIL wr_pulse: got %b want 1", o_pulse_ok); end
  endtask

  task automatic test_read_wait();
    tgt = 4'b0001; ws = 3; bg_rdy = 4'b0000; bus.PSLVERR_ALL = 4'b0000;
    bus.PRDATA_ALL = {32'h33333333, 32'h22222222, 32'h11111111, 32'h12345678};
    run_xfer(1'b0, 32'd1000 + 32'h008, 32'hFFFFFFFF, 4'b1111);
    tests++;
    if (o_rc !== 6) begin fails++; $display("FAIL rd_latency: got %0d want 6", o_rc); end
    tests++;
    if (RDATA !== 32'h12345678) begin fails++; $display("FAIL rd_data: got %h want 12345678", RDATA); end
    tests++;
    if (o_pstrb !== 4'b0000 || o_pwdata !== 32'd0) begin
      fails++;
      $display("FAIL rd_strb: got strb=%b pwdata=%h want 0000/0", o_pstrb, o_pwdata);
    end
    tests++;
    if (o_psel !== 4'b0001 || o_paddr !== 32'h8 || o_acc !== 4) begin
      fails++;
      $display("FAIL rd_bus: got psel=%b paddr=%h acc=%0d want 0001/8/4", o_psel, o_paddr, o_acc);
    end
  endtask

  task automatic test_write_err();
    tgt = 4'b1000; ws = 1; bg_rdy = 4'b0000; bus.PSLVERR_ALL = 4'b1000;
    run_xfer(1'b1, 32'd1000 + 32'h3FC, 32'h0000ABCD, 4'b1100);
    tests++;
    if (o_rc !== 4 || o_err !== 1'b1) begin
      fails++;
      $display("FAIL wr_err: got rc=%0d err=%b want 4/1", o_rc, o_err);
    end
    tests++;
    if (o_psel !== 4'b1000 || o_paddr !== 32'hFC) begin
      fails++;
      $display("FAIL wr_err_bus: got psel=%b paddr=%h want 1000/fc", o_psel, o_paddr);
    end
    tests++;
    if (RDATA !== 32'h12345678) begin
      fails++;
      $display("FAIL wr_keeps_rdata: got %h want 12345678", RDATA);
    end
  endtask

  task automatic test_timeout();
    tgt = 4'b0100; ws = 1000; bg_rdy = 4'b1011; bus.PSLVERR_ALL = 4'b1011;
    bus.PRDATA_ALL = {4{32'hFFFFFFFF}};
    run_xfer(1'b0, 32'd1000 + 32'h210, 32'd0, 4'b0000);
    tests++;
    if (o_rc !== 18 || o_acc !== 16) begin
      fails++;
      $display("FAIL timeout_latency: got rc=%0d acc=%0d want 18/16", o_rc, o_acc);
    end
    tests++;
    if (o_err !== 1'b1 || o_psel_rdy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_err: got err=%b psel_at_ready=%b want 1/0", o_err, o_psel_rdy);
    end
    tests++;
    if (RDATA !== 32'd0 || o_psel !== 4'b0100) begin
      fails++;
      $display("FAIL timeout_rdata: got rdata=%h psel=%b want 0/0100", RDATA, o_psel);
    end
    bg_rdy = 4'b0000; bus.PSLVERR_ALL = 4'b0000;
  endtask

  task automatic test_decode_err();
    tgt = 4'b0010; ws = 0;
    bus.PRDATA_ALL = {32'h0, 32'h0, 32'h0BADCAFE, 32'h0};
    run_xfer(1'b0, 32'd1000 + 32'h180, 32'd0, 4'b0000);
    tests++;
    if (o_rc !== 3 || RDATA !== 32'h0BADCAFE) begin
      fails++;
      $display("FAIL rd_slave1: got rc=%0d rdata=%h want 3/0badcafe", o_rc, RDATA);
    end
    run_xfer(1'b0, 32'd1000 + 32'h400, 32'd0, 4'b0000);
    tests++;
    if (o_rc !== 1 || o_err !== 1'b1 || o_psel !== 4'b0000) begin
      fails++;
      $display("FAIL dec_idx4: got rc=%0d err=%b psel=%b want 1/1/0000", o_rc, o_err, o_psel);
    end
    tests++;
    if (RDATA !== 32'd0) begin fails++; $display("FAIL dec_rdata: got %h want 0", RDATA); end
    run_xfer(1'b1, 32'd999, 32'h55555555, 4'b1111);
    tests++;
    if (o_rc !== 1 || o_err !== 1'b1 || o_psel !== 4'b0000) begin
      fails++;
      $display("FAIL dec_under: got rc=%0d err=%b psel=%b want 1/1/0000", o_rc, o_err, o_psel);
    end
  endtask

  task automatic test_back_to_back();
    tgt = 4'b0001; ws = 0;
    run_xfer(1'b1, 32'd1000 + 32'h010, 32'h11112222, 4'b1111);
    tests++;
    if (o_rc !== 3 || o_rearm_ok !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: got rc=%0d no_repeat=%b want 3/1", o_rc, o_rearm_ok);
    end
    tgt = 4'b1000;
    bus.PRDATA_ALL = {32'hCAFEF00D, 32'h0, 32'h0, 32'h0};
    run_xfer(1'b0, 32'd1000 + 32'h300, 32'd0, 4'b0000);
    tests++;
    if (o_rc !== 3 || o_psel !== 4'b1000 || RDATA !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL b2b_second: got rc=%0d psel=%b rdata=%h want 3/1000/cafef00d", o_rc,
               o_psel, RDATA);
    end
    tests++;
    if (o_rearm_ok !== 1'b1) begin fails++; $display("FAIL b2b_repeat: got %b want 1", o_rearm_ok); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic rdy_seen;
    tgt = 4'b0001; ws = 1000; bus.PREADY_ALL = 4'b0000;
    @(negedge clk);
    SWRITE = 1'b1; SADDR = 32'd1000 + 32'h020; SWDATA = 32'h77777777; SSTRB = 4'b1111;
    transfer = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.PENABLE) begin seen = 1'b1; break; end
    end
    tests++;
    if (seen !== 1'b1) begin fails++; $display("FAIL rstmid_access: got %b want 1", seen); end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bus.PSEL !== 4'b0000 || bus.PENABLE !== 1'b0 || RDATA !== 32'd0) begin
      fails++;
      $display("FAIL rstmid_async: got psel=%b pen=%b rdata=%h want 0000/0/0", bus.PSEL,
               bus.PENABLE, RDATA);
    end
    transfer = 1'b0;
    rdy_seen = READY;
    repeat (2) @(negedge clk) rdy_seen |= READY;
    rst = 1'b1;
    repeat (3) @(negedge clk) rdy_seen |= READY;
    tests++;
    if (rdy_seen !== 1'b0) begin fails++; $display("FAIL rstmid_ready: got %b want 0", rdy_seen); end
    tgt = 4'b0100; ws = 0;
    run_xfer(1'b1, 32'd1000 + 32'h2A0, 32'h89ABCDEF, 4'b0101);
    tests++;
    if (o_rc !== 3 || o_err !== 1'b0 || o_psel !== 4'b0100 || o_paddr !== 32'hA0) begin
      fails++;
      $display("FAIL rstmid_after: got rc=%0d err=%b psel=%b paddr=%h want 3/0/0100/a0", o_rc,
               o_err, o_psel, o_paddr);
    end
  endtask

  initial begin
    bus.PRDATA_ALL  = '0;
    bus.PREADY_ALL  = '0;
    bus.PSLVERR_ALL = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_write_err();
    test_timeout();
    test_decode_err();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
